// File: rtl/i2s_tx_serializer_pkg.sv
// Shared definitions for the I2S transmit serializer: FSM state encoding and
// default geometry. The FIFO feeding this block imports the same DEF_DATA_W
// so both ends agree on the frame width.
package i2s_tx_serializer_pkg;

  localparam int DEF_DATA_W  = 16;  // bits per channel
  localparam int DEF_CLK_DIV = 4;   // clk cycles per BCLK half-period

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator for the I2S serializer. Divides clk down to BCLK and
// flags the clk cycle on which BCLK is about to rise or fall, so the
// serializer can update SD/LRCLK exactly on the falling edge. Everything
// parks at 0 while run is low.
module i2s_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_bclk,
  output logic o_tick_rise,
  output logic o_tick_fall
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             w_toggle;

  assign w_toggle = i_run && (r_div == DIV_LAST);

  // Half-period counter and BCLK flop; cleared whenever run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (!i_run) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_toggle) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign o_bclk      = r_bclk;
  assign o_tick_rise = w_toggle & ~r_bclk;
  assign o_tick_fall = w_toggle &  r_bclk;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: pops stereo frames {left, right} from a FIFO and
// shifts them MSB-first on SD with LRCLK leading the slot by one BCLK.
// One frame is prefetched mid-frame so consecutive frames run without gaps.
// Build option: define I2S_UNDERRUN_HOLD_EN to repeat the last frame on
// underrun instead of sending a zero frame.
module i2s_tx_serializer
  import i2s_tx_serializer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                En,
  input  logic                Empty,
  input  logic [2*DATA_W-1:0] Rd_Data,
  output logic                Rd_En,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SD,
  output logic                Busy,
  output logic                Underrun,
  input  logic                Underrun_Clr
);

  localparam int              FRAME_W    = 2 * DATA_W;
  localparam int              P_W        = $clog2(FRAME_W);
  localparam logic [P_W-1:0]  P_LAST     = P_W'(FRAME_W - 1);
  localparam logic [P_W-1:0]  P_PREFETCH = P_W'(DATA_W - 1);   // fall entering p=DATA_W
  localparam logic [P_W-1:0]  P_LR_FIRST = P_W'(DATA_W - 1);
  localparam logic [P_W-1:0]  P_LR_LAST  = P_W'(FRAME_W - 2);

  state_t             r_state, w_state_next;
  logic [P_W-1:0]     r_p, w_p_next;
  logic [FRAME_W-1:0] r_shift, r_next_buf, w_fill;
  logic               r_next_valid, r_fetch_pend, r_lrclk, r_underrun;
  logic               w_run, w_bclk, w_tick_rise, w_tick_fall;
  logic               w_start_pop, w_capture, w_prefetch, w_boundary, w_exit;
  logic               w_lr_next, w_underrun_set;

  assign w_run = (r_state == ST_RUN);

  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .o_bclk      (w_bclk),
    .o_tick_rise (w_tick_rise),
    .o_tick_fall (w_tick_fall)
  );

  // The divider can never announce both edges in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n) !(w_tick_rise && w_tick_fall));

  assign w_boundary     = w_tick_fall && (r_p == P_LAST);
  assign w_exit         = w_boundary && !En;
  assign w_prefetch     = w_tick_fall && (r_p == P_PREFETCH) && !r_next_valid && !Empty;
  assign w_underrun_set = w_boundary && En && !r_next_valid;
  assign w_p_next       = (r_p == P_LAST) ? '0 : r_p + 1'b1;
  assign w_lr_next      = (w_p_next >= P_LR_FIRST) && (w_p_next <= P_LR_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and the single-cycle start pop.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a
    // missed branch would infer a latch.
    w_state_next = r_state;
    w_start_pop  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE:  if (En && !Empty) begin
                  w_start_pop  = 1'b1;
                  w_state_next = ST_FETCH;
                end
      ST_FETCH: w_state_next = ST_WAIT;
      ST_WAIT:  begin
                  w_capture    = 1'b1;
                  w_state_next = ST_RUN;
                end
      ST_RUN:   if (w_exit) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Gated by rst_n so a pop cannot be issued while reset holds the FSM.
  assign Rd_En = rst_n && (w_start_pop || w_prefetch);

`ifdef I2S_UNDERRUN_HOLD_EN
  logic [FRAME_W-1:0] r_last;

  // Copy of the frame currently on the wire, replayed on underrun.
  always_ff @(posedge clk) begin
    if (w_capture)                      r_last <= Rd_Data;
    else if (w_boundary && r_next_valid) r_last <= r_next_buf;
  end

  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  // Bit counter, shift register and LRCLK, all updated on BCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_shift <= '0;
      r_lrclk <= 1'b0;
    end else if (w_capture) begin
      r_p     <= '0;
      r_shift <= Rd_Data;
      r_lrclk <= 1'b0;
    end else if (w_exit) begin
      r_p     <= '0;
      r_shift <= '0;
      r_lrclk <= 1'b0;
    end else if (w_tick_fall) begin
      r_p     <= w_p_next;
      r_lrclk <= w_lr_next;
      if (w_boundary) r_shift <= r_next_valid ? r_next_buf : w_fill;
      else            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
    end
  end

  // Prefetch bookkeeping and the sticky underrun flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pend <= 1'b0;
      r_next_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_fetch_pend <= w_prefetch;
      if (w_boundary)        r_next_valid <= 1'b0;
      else if (r_fetch_pend) r_next_valid <= 1'b1;
      if (w_underrun_set)    r_underrun <= 1'b1;
      else if (Underrun_Clr) r_underrun <= 1'b0;
    end
  end

  // Prefetched frame payload, qualified by r_next_valid.
  always_ff @(posedge clk) begin
    // NOTE: pure data storage is left without reset; its valid flag is
    // reset instead, which keeps the reset tree small.
    if (r_fetch_pend) r_next_buf <= Rd_Data;
  end

  assign BCLK     = w_bclk;
  assign LRCLK    = r_lrclk;
  assign SD       = r_shift[FRAME_W-1];
  assign Busy     = (r_state != ST_IDLE);
  assign Underrun = r_underrun;

endmodule
